// File: rtl/fnd_scan_counter.sv
// rtl/fnd_scan_counter.sv - four-digit BCD up/down counter with time-multiplexed 7-segment digit scanner
module fnd_scan_counter #(
    parameter int P_TICK_DIV = 50_000_000,
    parameter int P_SCAN_DIV = 50_000
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Run,
    input  logic        i_Up,
    input  logic        i_Clr,
    output logic [3:0]  o_Num,
    output logic [3:0]  o_Digit,
    output logic [15:0] o_Value,
    output logic        o_Carry
);

    localparam int TW = (P_TICK_DIV > 2) ? $clog2(P_TICK_DIV) : 1;
    localparam int SW = (P_SCAN_DIV > 2) ? $clog2(P_SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(P_TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(P_SCAN_DIV - 1);

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [15:0]   next_value;
    logic          wrap;

    logic [SW-1:0] scan_cnt;
    logic [1:0]    scan_idx;
    logic [1:0]    idx_next;
    logic          scan_last;
    logic [3:0]    sel_nibble;

    assign tick = i_Run && (tick_cnt == TICK_LAST);

    // Ripple the +1/-1 through the digits; the chain surviving past digit 3 is the wrap.
    always_comb begin
        next_value = o_Value;
        wrap       = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (wrap) begin
                if (i_Up) begin
                    if (o_Value[4*k +: 4] >= 4'd9) begin
                        next_value[4*k +: 4] = 4'd0;
                    end else begin
                        next_value[4*k +: 4] = o_Value[4*k +: 4] + 4'd1;
                        wrap = 1'b0;
                    end
                end else begin
                    if (o_Value[4*k +: 4] == 4'd0) begin
                        next_value[4*k +: 4] = 4'd9;
                    end else begin
                        next_value[4*k +: 4] = o_Value[4*k +: 4] - 4'd1;
                        wrap = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            tick_cnt <= '0;
            o_Value  <= 16'h0000;
            o_Carry  <= 1'b0;
        end else if (i_Clr) begin
            tick_cnt <= '0;
            o_Value  <= 16'h0000;
            o_Carry  <= 1'b0;
        end else begin
            o_Carry <= 1'b0;
            if (i_Run) begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            end
            if (tick) begin
                o_Value <= next_value;
                o_Carry <= wrap;
            end
        end
    end

    assign scan_last = (scan_cnt == SCAN_LAST);
    assign idx_next  = scan_last ? scan_idx + 2'd1 : scan_idx;

    always_comb begin
        sel_nibble = o_Value[3:0];
        case (idx_next)
            2'd0: sel_nibble = o_Value[3:0];
            2'd1: sel_nibble = o_Value[7:4];
            2'd2: sel_nibble = o_Value[11:8];
            2'd3: sel_nibble = o_Value[15:12];
            default: sel_nibble = o_Value[3:0];
        endcase
    end

    // Digit select and nibble are registered from the same index so they always switch together.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            scan_cnt <= '0;
            scan_idx <= 2'd0;
            o_Digit  <= 4'b1110;
            o_Num    <= 4'h0;
        end else begin
            scan_cnt <= scan_last ? '0 : scan_cnt + 1'b1;
            scan_idx <= idx_next;
            o_Digit  <= ~(4'b0001 << idx_next);
            o_Num    <= sel_nibble;
        end
    end

endmodule

// File: tb/tb_fnd_scan_counter.sv
// tb/tb_fnd_scan_counter.sv - table-driven and randomized check of fnd_scan_counter against an arithmetic reference model
module tb_fnd_scan_counter;

    localparam int TICK = 4;
    localparam int SCAN = 3;

    logic        i_Clk = 1'b0;
    logic        i_Rst_n = 1'b1;
    logic        i_Run = 1'b0;
    logic        i_Up = 1'b1;
    logic        i_Clr = 1'b0;
    logic [3:0]  o_Num;
    logic [3:0]  o_Digit;
    logic [15:0] o_Value;
    logic        o_Carry;

    int vectors = 0;
    int miscompares = 0;
    bit active = 1'b0;

    fnd_scan_counter #(.P_TICK_DIV(TICK), .P_SCAN_DIV(SCAN)) dut (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Run(i_Run), .i_Up(i_Up), .i_Clr(i_Clr),
        .o_Num(o_Num), .o_Digit(o_Digit), .o_Value(o_Value), .o_Carry(o_Carry)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: count is a plain integer 0..9999, digits extracted by division.
    function automatic int digit_of(input int v, input int k);
        int d = 1;
        for (int j = 0; j < k; j++) d = d * 10;
        return (v / d) % 10;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = 16'h0;
        for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'(digit_of(v, k));
        return r;
    endfunction

    int       m_count, m_pre, m_scan, m_idx;
    logic [3:0] m_num, m_digit;
    logic     m_carry;

    always @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            m_count <= 0; m_pre <= 0; m_carry <= 1'b0;
            m_scan <= 0; m_idx <= 0; m_digit <= 4'b1110; m_num <= 4'h0;
        end else begin
            int ni;
            ni = (m_scan == SCAN - 1) ? (m_idx + 1) % 4 : m_idx;
            m_scan  <= (m_scan + 1) % SCAN;
            m_idx   <= ni;
            m_digit <= ~(4'b0001 << ni);
            m_num   <= 4'(digit_of(m_count, ni));
            if (i_Clr) begin
                m_count <= 0; m_pre <= 0; m_carry <= 1'b0;
            end else begin
                m_carry <= 1'b0;
                if (i_Run) begin
                    if (m_pre == TICK - 1) begin
                        m_pre   <= 0;
                        m_count <= i_Up ? (m_count + 1) % 10000 : (m_count + 9999) % 10000;
                        m_carry <= i_Up ? (m_count == 9999) : (m_count == 0);
                    end else begin
                        m_pre <= m_pre + 1;
                    end
                end
            end
        end
    end

    always @(negedge i_Clk) begin
        if (active)
            check("model", {7'd0, o_Num, o_Digit, o_Value, o_Carry},
                  {7'd0, m_num, m_digit, to_bcd(m_count), m_carry});
    end

    typedef struct {
        logic        run;
        logic        up;
        logic        clr;
        int          n;
        logic [15:0] exp_value;
        logic        exp_carry;
    } vec_t;

    vec_t tbl[14];

    task automatic cycles(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic drive(input logic run, input logic up, input logic clr);
        i_Run = run; i_Up = up; i_Clr = clr;
    endtask

    initial begin
        logic [3:0] dg [4];
        logic [3:0] nm [4];
        logic [3:0] prev;
        bit found;

        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1,    16'h0000, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 36,   16'h0009, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 4,    16'h0010, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 356,  16'h0099, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 4,    16'h0100, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 3596, 16'h0999, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 4,    16'h1000, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 4,    16'h0999, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1,    16'h0000, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 4,    16'h9999, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1,    16'h9999, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 3,    16'h0000, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1,    16'h0000, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 20,   16'h0000, 1'b0};

        dg[0] = 4'b1110; dg[1] = 4'b1101; dg[2] = 4'b1011; dg[3] = 4'b0111;
        nm[0] = 4'h4;    nm[1] = 4'h3;    nm[2] = 4'h2;    nm[3] = 4'h1;

        #1 i_Rst_n = 1'b0;
        active = 1'b1;
        #1;
        check("reset_value", {16'd0, o_Value}, 32'h0);
        check("reset_digit", {28'd0, o_Digit}, 32'hE);
        check("reset_num", {28'd0, o_Num}, 32'h0);
        check("reset_carry", {31'd0, o_Carry}, 32'h0);
        cycles(2);
        i_Rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].run, tbl[i].up, tbl[i].clr);
            cycles(tbl[i].n);
            check($sformatf("tbl%0d_value", i), {16'd0, o_Value}, {16'd0, tbl[i].exp_value});
            check($sformatf("tbl%0d_carry", i), {31'd0, o_Carry}, {31'd0, tbl[i].exp_carry});
        end

        // Run gating: freeze after two prescaler cycles, resume, tick lands two cycles later.
        drive(1'b0, 1'b1, 1'b1); cycles(1);
        drive(1'b1, 1'b1, 1'b0); cycles(2);
        drive(1'b0, 1'b1, 1'b0); cycles(10);
        check("gate_frozen", {16'd0, o_Value}, 32'h0);
        drive(1'b1, 1'b1, 1'b0); cycles(1);
        check("gate_resume1", {16'd0, o_Value}, 32'h0);
        cycles(1);
        check("gate_resume2", {16'd0, o_Value}, 32'h1);

        // Clear coincident with a tick, then clear of a partially elapsed prescaler.
        drive(1'b0, 1'b1, 1'b1); cycles(1);
        drive(1'b1, 1'b1, 1'b0); cycles(42 * TICK + 3);
        check("pre_clear_value", {16'd0, o_Value}, 32'h0042);
        drive(1'b1, 1'b1, 1'b1); cycles(1);
        check("clr_tick_value", {16'd0, o_Value}, 32'h0);
        check("clr_tick_carry", {31'd0, o_Carry}, 32'h0);
        drive(1'b1, 1'b1, 1'b0); cycles(2);
        drive(1'b1, 1'b1, 1'b1); cycles(1);
        drive(1'b1, 1'b1, 1'b0); cycles(3);
        check("clr_pre_hold", {16'd0, o_Value}, 32'h0);
        cycles(1);
        check("clr_pre_tick", {16'd0, o_Value}, 32'h1);

        // Scanner on 1234 with counting stopped.
        drive(1'b0, 1'b1, 1'b1); cycles(1);
        drive(1'b1, 1'b1, 1'b0); cycles(1234 * TICK);
        drive(1'b0, 1'b1, 1'b0);
        check("scan_value", {16'd0, o_Value}, 32'h1234);
        prev = o_Digit;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge i_Clk);
            if (o_Digit == 4'b1110 && prev != 4'b1110) found = 1'b1;
            prev = o_Digit;
        end
        if (!found) begin
            miscompares++;
            vectors++;
            $display("FAIL scan_sync: got digit %b, no step to 1110 within 20 cycles", o_Digit);
        end
        for (int i = 0; i < 12; i++) begin
            check($sformatf("scan%0d", i), {24'd0, o_Digit, o_Num}, {24'd0, dg[(i / 3) % 4], nm[(i / 3) % 4]});
            if (i < 11) @(negedge i_Clk);
        end

        // Asynchronous reset mid-count.
        drive(1'b1, 1'b1, 1'b0); cycles(5);
        @(posedge i_Clk);
        #2 i_Rst_n = 1'b0;
        #1;
        check("rst_mid_value", {16'd0, o_Value}, 32'h0);
        check("rst_mid_digit", {28'd0, o_Digit}, 32'hE);
        check("rst_mid_num", {28'd0, o_Num}, 32'h0);
        check("rst_mid_carry", {31'd0, o_Carry}, 32'h0);
        @(negedge i_Clk);
        i_Rst_n = 1'b1;
        cycles(2);
        check("rel_value2", {16'd0, o_Value}, 32'h0);
        check("rel_digit2", {28'd0, o_Digit}, 32'hE);
        cycles(1);
        check("rel_value3", {16'd0, o_Value}, 32'h0);
        check("rel_digit3", {28'd0, o_Digit}, 32'hD);
        cycles(1);
        check("rel_value4", {16'd0, o_Value}, 32'h1);

        // Random run/up/clear traffic checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 60) == 0);
            @(negedge i_Clk);
        end

        active = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        miscompares++;
        $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fnd_scan_counter.md
# fnd_scan_counter

Four-digit BCD up/down counter with a time-multiplexed digit scanner for the 7-segment display path. It counts on a prescaled tick and scans the four digits in turn. Each scan step presents one digit's BCD nibble on `o_Num`, which feeds the downstream 4-bit-to-7-segment decoder. It also drives the matching active-low digit-select line.

## Interface
- `P_TICK_DIV`, default 50_000_000: clock cycles per count tick (1 Hz at 50 MHz). Minimum 2.
- `P_SCAN_DIV`, default 50_000: clock cycles per digit scan step (1 kHz step rate). Minimum 2.

- `i_Clk`, input, 1: system clock. Everything is on the rising edge.
- `i_Rst_n`, input, 1: asynchronous active-low reset.
- `i_Run`, input, 1: count enable. It gates the tick prescaler only.
- `i_Up`, input, 1: direction. 1 = increment, 0 = decrement.
- `i_Clr`, input, 1: synchronous clear of the count value and the tick prescaler.
- `o_Num`, output, 4: BCD nibble of the currently selected digit, sent to the decoder.
- `o_Digit`, output, 4: digit select, one-cold and active-low. Bit 0 is the least significant digit.
- `o_Value`, output, 16: full BCD count. Nibble k = digit k, nibble 0 = ones.
- `o_Carry`, output, 1: one-cycle pulse on wrap (9999→0000 up, or 0000→9999 down).

## Operation
- **Reset values** (immediately on `i_Rst_n` low, regardless of clock):
  - `o_Value` = 16'h0000, `o_Num` = 4'h0, `o_Digit` = 4'b1110, `o_Carry` = 0.
  - Prescaler, scan divider and digit index = 0.
- **Tick prescaler:**
  - Counts 0..`P_TICK_DIV`-1 while `i_Run`=1 and holds its value while `i_Run`=0.
  - Tick is asserted in the cycle the prescaler equals `P_TICK_DIV`-1 with `i_Run`=1. The prescaler then returns to 0.
- **BCD count on tick:**
  - `i_Up` is sampled in the tick cycle.
  - Up: ones +1; a digit at 9 becomes 0 and carries into the next digit.
  - Down: ones −1; a digit at 0 becomes 9 and borrows from the next digit.
  - Every digit stays in 0..9; no nibble ever holds A..F.
- **Wrap:**
  - Up from 16'h9999 gives 16'h0000 with `o_Carry`=1.
  - Down from 16'h0000 gives 16'h9999 with `o_Carry`=1.
  - `o_Carry` is 0 in every other cycle.
- **Clear priority:**
  - `i_Clr`=1 overrides tick and `i_Run`: next cycle `o_Value`=0, prescaler=0, `o_Carry`=0.
  - Clear does not affect the scanner.
- **Scanner:**
  - Free-running and independent of `i_Run` and `i_Clr`.
  - The scan divider counts 0..`P_SCAN_DIV`-1. At terminal count the 2-bit digit index advances 0→1→2→3→0.
  - `o_Digit` = ~(1 << index), so index 0 → 4'b1110 and index 3 → 4'b0111.
  - `o_Num` = `o_Value` nibble[index].
- **Glitch-free selection:** `o_Digit` and `o_Num` are both registered and change on the same edge, so the decoder never sees a nibble paired with the wrong digit.

## Timing
- **Count latency:** `o_Value` (and `o_Carry`) update on the edge ending the tick cycle. With `i_Run` held high from the prescaler at 0, the first update occurs exactly `P_TICK_DIV` cycles after `i_Run` rises.
- **Run gating:** deasserting `i_Run` mid-interval freezes the prescaler. Reasserting resumes it, so the remaining cycles to the tick equal `P_TICK_DIV` minus the count already elapsed.
- **Scan step:** the digit index changes every `P_SCAN_DIV` cycles. `o_Digit` and `o_Num` reflect the new index on the edge after the terminal count.
- **Display latency:** `o_Num` follows changes of `o_Value` for the selected digit one cycle later.
- **`o_Carry`:** high for exactly one cycle, aligned with the wrapped `o_Value`.
- **Reset mid-operation:** everything returns to the reset values asynchronously. The first tick after release requires a full `P_TICK_DIV` cycles; the first scan step requires a full `P_SCAN_DIV` cycles.

## Test plan
- **Reset:** `P_TICK_DIV`=4, `P_SCAN_DIV`=3. Assert `i_Rst_n`=0 mid-count → outputs immediately 0000, `o_Digit`=1110, `o_Carry`=0. Release → first increment after 4 cycles.
- **BCD carry:** preload to 0009 by ticks, `i_Up`=1, one tick → `o_Value`=0010. From 0099 → 0100. From 0999 → 1000. No A..F nibble ever appears.
- **Wrap:**
  - From 9999 with `i_Up`=1, one tick → 0000 with `o_Carry`=1 for one cycle.
  - From 0000 with `i_Up`=0, one tick → 9999 with `o_Carry`=1.
  - From 1000 with `i_Up`=0 → 0999.
- **Run gating and clear:**
  - Drop `i_Run` after 2 prescaler cycles for 10 cycles, then restore → the next tick occurs 2 cycles after restore.
  - `i_Clr`=1 coincident with a tick at 0042 → `o_Value`=0000 and `o_Carry`=0.
- **Scanner:** `o_Value`=1234. Over 12 cycles, `o_Digit`/`o_Num` sequence = 1110/4, 1101/3, 1011/2, 0111/1 then repeats, with each pair changing on the same edge. Scanning continues while `i_Run`=0.
